// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending sequencer: credit, vend window, unit-coin change return
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   coin_valid/coin_value coin strobe and its value in credit units
//   select_valid/select_id product selection strobe, id 1-7 (0 = none)
//   cancel                refund request strobe
//   product_dispense      product code shown during the vend window, else 0
//   busy                  high while vending or returning change
//   credit                current credit
//   change_pulse          one change coin ejected this cycle
//   deny                  selection refused, credit below price
//   coin_reject           coin not accepted
module vend_controller #(
  parameter int CREDIT_W        = 8,
  parameter int PRICE           = 25,
  parameter int CHANGE_UNIT     = 5,
  parameter int DISPENSE_CYCLES = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                select_valid,
  input  logic [2:0]          select_id,
  input  logic                cancel,
  output logic [2:0]          product_dispense,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_pulse,
  output logic                deny,
  output logic                coin_reject
);

  localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C   = CREDIT_W'(CHANGE_UNIT);

  typedef enum logic [1:0] {IDLE, VEND, REFUND} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  logic               vend_ok;
  logic               coin_nz;
  logic [CREDIT_W-1:0] base;
  logic [CREDIT_W:0]  sum;
  logic               coin_ok;
  logic [CREDIT_W-1:0] credit_idle;

  // IDLE next-credit: the coin is checked for overflow against the credit
  // left after any same-cycle price deduction (or cancel clear).
  always_comb begin
    vend_ok     = 1'b0;
    coin_nz     = 1'b0;
    base        = credit;
    sum         = '0;
    coin_ok     = 1'b0;
    credit_idle = credit;
    vend_ok = select_valid && (select_id != 3'd0) && !cancel && (credit >= PRICE_C);
    coin_nz = coin_valid && (coin_value != '0);
    if (vend_ok)
      base = credit - PRICE_C;
    else if (cancel && (credit < UNIT_C))
      base = '0;
    sum         = {1'b0, base} + {1'b0, coin_value};
    coin_ok     = coin_nz && !sum[CREDIT_W];
    credit_idle = coin_ok ? sum[CREDIT_W-1:0] : base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      product_dispense <= 3'd0;
      busy             <= 1'b0;
      credit           <= '0;
      change_pulse     <= 1'b0;
      deny             <= 1'b0;
      coin_reject      <= 1'b0;
    end else begin
      deny         <= 1'b0;
      coin_reject  <= 1'b0;
      change_pulse <= 1'b0;
      case (state)
        IDLE: begin
          coin_reject <= coin_nz && sum[CREDIT_W];
          if (cancel) begin
            if (credit >= UNIT_C) begin
              // first change coin goes out in the first REFUND cycle
              credit       <= credit_idle - UNIT_C;
              change_pulse <= 1'b1;
              busy         <= 1'b1;
              state        <= REFUND;
            end else begin
              credit <= credit_idle;
            end
          end else if (select_valid && (select_id != 3'd0)) begin
            credit <= credit_idle;
            if (vend_ok) begin
              product_dispense <= select_id;
              busy             <= 1'b1;
              cnt              <= CNT_LOAD;
              state            <= VEND;
            end else begin
              deny <= 1'b1;
            end
          end else begin
            credit <= credit_idle;
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          if (cnt == '0) begin
            product_dispense <= 3'd0;
            if (credit >= UNIT_C) begin
              credit       <= credit - UNIT_C;
              change_pulse <= 1'b1;
              state        <= REFUND;
            end else begin
              credit <= '0;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        REFUND: begin
          coin_reject <= coin_valid;
          // credit shown here is already post-decrement for this cycle's pulse
          if (credit >= UNIT_C) begin
            credit       <= credit - UNIT_C;
            change_pulse <= 1'b1;
          end else begin
            credit <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing FSM for the vending machine. Accumulates inserted credit, arbitrates a product selection against the price, and drives the 3-bit product code consumed by the dispense LED display for a fixed dispense window.
- Returns change one unit-coin pulse at a time.
- Sits between the coin/keypad front end and the product display/dispense mechanism.

Parameters:
- CREDIT_W, 8: width of credit register and coin_value.
- PRICE, 25: price of every product, in credit units (cents).
- CHANGE_UNIT, 5: value of one returned change coin.
- DISPENSE_CYCLES, 50: clock cycles product_dispense is held non-zero per vend; must be >= 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- coin_valid, input, 1: one-cycle strobe, coin inserted.
- coin_value, input, CREDIT_W: value of inserted coin; sampled when coin_valid=1.
- select_valid, input, 1: one-cycle strobe, product chosen.
- select_id, input, 3: product number 1-7; 0 = no product.
- cancel, input, 1: one-cycle strobe, refund request.
- product_dispense, output, 3: product code to display; 0 when not vending.
- busy, output, 1: high in VEND or REFUND.
- credit, output, CREDIT_W: current credit.
- change_pulse, output, 1: one change coin ejected this cycle.
- deny, output, 1: one-cycle pulse, selection refused for insufficient credit.
- coin_reject, output, 1: one-cycle pulse, coin not accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE. product_dispense=0, credit=0, busy=0. change_pulse, deny and coin_reject all 0. Dispense counter=0.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, VEND, REFUND.
- IDLE, coin handling:
  - coin_valid with coin_value=0: ignored, no pulse.
  - coin_valid where credit+coin_value exceeds 2^CREDIT_W-1 (evaluated after any same-cycle PRICE deduction): coin_reject=1 next cycle, credit unchanged by that coin.
  - Otherwise the coin is added to credit next cycle.
- IDLE, priority: cancel > select_valid. Coin accumulation happens in parallel with either.
- IDLE, cancel:
  - credit >= CHANGE_UNIT: go to REFUND.
  - Otherwise: credit cleared to 0, stay IDLE.
  - A pending select in the same cycle is dropped.
- IDLE, select_valid:
  - select_id=0: ignored.
  - credit (pre-coin value of this cycle) < PRICE: deny=1 for one cycle, credit unchanged apart from this cycle's coin.
  - credit >= PRICE: next cycle credit = credit - PRICE + accepted coin, product_dispense=select_id, busy=1, state=VEND, counter loaded.
- VEND:
  - product_dispense holds select_id for exactly DISPENSE_CYCLES cycles, starting the cycle after the select edge.
  - On the last cycle, next state is REFUND if credit >= CHANGE_UNIT, else IDLE with residual credit cleared to 0. product_dispense returns to 0 on exit.
- REFUND:
  - Each cycle: change_pulse=1 and credit -= CHANGE_UNIT while credit >= CHANGE_UNIT.
  - Pulse count = floor(credit/CHANGE_UNIT). The final pulse is in the cycle whose post-decrement credit < CHANGE_UNIT.
  - After the final pulse: credit cleared to 0 (residue < CHANGE_UNIT forfeited), then IDLE.
  - busy is high in every REFUND cycle.
- Non-IDLE states:
  - coin_valid gives coin_reject=1 next cycle, credit unaffected.
  - select_valid and cancel are ignored; no deny.
- Reset mid-VEND/REFUND: product_dispense=0 and credit=0 immediately; no further change pulses.
- deny, coin_reject and change_pulse are never high for more than one cycle per event.

Test Plan:
All scenarios use PRICE=25, CHANGE_UNIT=5, DISPENSE_CYCLES=4, CREDIT_W=8.
1. Coins 10,10,5 then select_id=3 -> product_dispense=3 for exactly 4 cycles then 0; credit=0; no change_pulse; busy high 4 cycles.
2. Coins 25,10 then select_id=7 -> product_dispense=7 for 4 cycles, then 2 consecutive change_pulse, credit 10->5->0, IDLE.
3. Coin 10 then select_id=2 -> deny one cycle, credit stays 10, product_dispense=0. Then cancel -> 2 change_pulse, credit 0.
4. Credit 250, coin 10 -> coin_reject one cycle, credit 250. Coin 5 -> credit 255. Coin in VEND -> coin_reject, credit unchanged.
5. Credit 25, coin 5 and select_id=4 in same cycle -> vend 4, credit 5 during VEND, 1 change_pulse after, then 0.
6. Assert rst_n=0 in 2nd VEND cycle with credit 10 -> product_dispense=0, credit=0, busy=0 without clock edge; no change_pulse after release.
